// File: rtl/rec_play_ctrl.sv
// Record/playback sequencer for a slotted SRAM audio recorder: codec init handshake,
// key-driven record/play/pause/stop control, per-slot lengths and end-of-play detection.
module rec_play_ctrl #(
  parameter int ADDR_W   = 20,
  parameter int SLOTS    = 4,
  parameter int INIT_DLY = 3,
  localparam int SW      = $clog2(SLOTS),
  localparam int LW      = ADDR_W - SW + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_key_rec,
  input  logic              i_key_play,
  input  logic              i_key_stop,
  input  logic [SW-1:0]     i_slot_sel,
  input  logic [4:0]        i_speed,
  input  logic              i_init_done,
  input  logic              i_sample_tick,
  input  logic              i_play_finish,
  output logic [2:0]        o_state,
  output logic              o_init_start,
  output logic              o_rec_en,
  output logic              o_play_en,
  output logic              o_rec_start,
  output logic              o_rec_pause,
  output logic              o_rec_stop,
  output logic              o_play_start,
  output logic              o_play_pause,
  output logic              o_play_stop,
  output logic [ADDR_W-1:0] o_base_addr,
  output logic [LW-1:0]     o_len
);

  localparam int PW = ADDR_W - SW + 4;
  localparam int DW = (INIT_DLY > 0) ? $clog2(INIT_DLY + 1) : 1;
  localparam logic [31:0] INIT_LAST = (INIT_DLY > 0) ? 32'(INIT_DLY - 1) : 32'd0;
  localparam logic [LW-1:0] LEN_MAX = {1'b1, {(LW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_INIT       = 3'd1,
    S_AWAIT      = 3'd2,
    S_REC        = 3'd3,
    S_REC_PAUSE  = 3'd4,
    S_PLAY       = 3'd5,
    S_PLAY_PAUSE = 3'd6
  } state_t;

  state_t         state, state_d;
  logic           rec_q, play_q, stop_q;
  logic [DW-1:0]  dly_cnt, dly_d;
  logic [SW-1:0]  slot, slot_d;
  logic [PW-1:0]  play_cnt, play_cnt_d;
  logic [LW-1:0]  len_mem [SLOTS];

  logic           len_we;
  logic [SW-1:0]  len_waddr;
  logic [LW-1:0]  len_wdata;

  logic init_start_d, rec_start_d, rec_pause_d, rec_stop_d;
  logic play_start_d, play_pause_d, play_stop_d;

  logic           rec_edge, play_edge, stop_edge;
  logic [LW-1:0]  cur_len, sel_len, len_inc;
  logic [3:0]     spd;
  logic [PW-1:0]  cnt_next, len_ext, fast_prod, slow_prod;
  logic           play_end, rec_full, idle_done;
  logic           unused_speed_linear;

  assign unused_speed_linear = i_speed[4];

  assign rec_edge  = i_key_rec  & ~rec_q;
  assign play_edge = i_key_play & ~play_q;
  assign stop_edge = i_key_stop & ~stop_q;

  assign cur_len   = len_mem[slot];
  assign sel_len   = len_mem[i_slot_sel];
  assign len_inc   = cur_len + LW'(1);
  assign rec_full  = i_sample_tick && (len_inc == LEN_MAX);
  assign idle_done = 32'(dly_cnt) >= INIT_LAST;

  // End-of-play is judged on the count including this cycle's tick so the stop
  // pulse follows the final tick by one cycle.
  assign spd       = {1'b0, i_speed[2:0]} + 4'd1;
  assign cnt_next  = play_cnt + PW'((state == S_PLAY) && i_sample_tick);
  assign len_ext   = PW'(cur_len);
  assign fast_prod = cnt_next * PW'(spd);
  assign slow_prod = len_ext * PW'(spd);
  assign play_end  = i_speed[3] ? (fast_prod >= len_ext) : (cnt_next >= slow_prod);

  // Next-state and pulse decode; stop-like events always outrank pause/resume.
  always_comb begin
    state_d      = state;
    slot_d       = slot;
    play_cnt_d   = play_cnt;
    dly_d        = '0;
    len_we       = 1'b0;
    len_waddr    = slot;
    len_wdata    = len_inc;
    init_start_d = 1'b0;
    rec_start_d  = 1'b0;
    rec_pause_d  = 1'b0;
    rec_stop_d   = 1'b0;
    play_start_d = 1'b0;
    play_pause_d = 1'b0;
    play_stop_d  = 1'b0;

    case (state)
      S_IDLE: begin
        if (idle_done) begin
          init_start_d = 1'b1;
          state_d      = S_INIT;
        end else begin
          dly_d = dly_cnt + DW'(1);
        end
      end
      S_INIT: begin
        if (i_init_done) state_d = S_AWAIT;
      end
      S_AWAIT: begin
        if (rec_edge) begin
          slot_d      = i_slot_sel;
          len_we      = 1'b1;
          len_waddr   = i_slot_sel;
          len_wdata   = '0;
          rec_start_d = 1'b1;
          state_d     = S_REC;
        end else if (play_edge) begin
          slot_d = i_slot_sel;
          if (sel_len != '0) begin
            play_start_d = 1'b1;
            play_cnt_d   = '0;
            state_d      = S_PLAY;
          end
        end
      end
      S_REC: begin
        len_we = i_sample_tick;
        if (stop_edge || rec_full) begin
          rec_stop_d = 1'b1;
          state_d    = S_AWAIT;
        end else if (rec_edge) begin
          rec_pause_d = 1'b1;
          state_d     = S_REC_PAUSE;
        end
      end
      S_REC_PAUSE: begin
        if (stop_edge) begin
          rec_stop_d = 1'b1;
          state_d    = S_AWAIT;
        end else if (rec_edge) begin
          rec_pause_d = 1'b1;
          state_d     = S_REC;
        end
      end
      S_PLAY, S_PLAY_PAUSE: begin
        play_cnt_d = cnt_next;
        if (stop_edge || play_end || i_play_finish) begin
          play_stop_d = 1'b1;
          state_d     = S_AWAIT;
        end else if (play_edge) begin
          play_pause_d = 1'b1;
          state_d      = (state == S_PLAY) ? S_PLAY_PAUSE : S_PLAY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      rec_q        <= 1'b1;
      play_q       <= 1'b1;
      stop_q       <= 1'b1;
      dly_cnt      <= '0;
      slot         <= '0;
      play_cnt     <= '0;
      o_init_start <= 1'b0;
      o_rec_start  <= 1'b0;
      o_rec_pause  <= 1'b0;
      o_rec_stop   <= 1'b0;
      o_play_start <= 1'b0;
      o_play_pause <= 1'b0;
      o_play_stop  <= 1'b0;
      for (int i = 0; i < SLOTS; i++) len_mem[i] <= '0;
    end else begin
      state        <= state_d;
      rec_q        <= i_key_rec;
      play_q       <= i_key_play;
      stop_q       <= i_key_stop;
      dly_cnt      <= dly_d;
      slot         <= slot_d;
      play_cnt     <= play_cnt_d;
      o_init_start <= init_start_d;
      o_rec_start  <= rec_start_d;
      o_rec_pause  <= rec_pause_d;
      o_rec_stop   <= rec_stop_d;
      o_play_start <= play_start_d;
      o_play_pause <= play_pause_d;
      o_play_stop  <= play_stop_d;
      if (len_we) len_mem[len_waddr] <= len_wdata;
    end
  end

  assign o_state     = state;
  assign o_rec_en    = (state == S_REC);
  assign o_play_en   = (state == S_PLAY);
  assign o_base_addr = {slot, {(ADDR_W-SW){1'b0}}};
  assign o_len       = cur_len;

endmodule

// File: tb/tb_rec_play_ctrl.sv
// Bench for rec_play_ctrl: directed scenarios with literal expectations, then random
// stimulus, all outputs compared every cycle against a behavioural model.
module tb_rec_play_ctrl;

  localparam int ADDR_W   = 8;
  localparam int SLOTS    = 4;
  localparam int INIT_DLY = 3;
  localparam int SW       = 2;
  localparam int LW       = ADDR_W - SW + 1;
  localparam int LMAX     = 1 << (ADDR_W - SW);

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_key_rec = 1'b0, i_key_play = 1'b0, i_key_stop = 1'b0;
  logic [SW-1:0]     i_slot_sel = '0;
  logic [4:0]        i_speed = '0;
  logic              i_init_done = 1'b0, i_sample_tick = 1'b0, i_play_finish = 1'b0;
  logic [2:0]        o_state;
  logic              o_init_start, o_rec_en, o_play_en;
  logic              o_rec_start, o_rec_pause, o_rec_stop;
  logic              o_play_start, o_play_pause, o_play_stop;
  logic [ADDR_W-1:0] o_base_addr;
  logic [LW-1:0]     o_len;

  always #5 i_clk = ~i_clk;

  rec_play_ctrl #(.ADDR_W(ADDR_W), .SLOTS(SLOTS), .INIT_DLY(INIT_DLY)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_key_rec(i_key_rec), .i_key_play(i_key_play), .i_key_stop(i_key_stop),
    .i_slot_sel(i_slot_sel), .i_speed(i_speed),
    .i_init_done(i_init_done), .i_sample_tick(i_sample_tick), .i_play_finish(i_play_finish),
    .o_state(o_state), .o_init_start(o_init_start),
    .o_rec_en(o_rec_en), .o_play_en(o_play_en),
    .o_rec_start(o_rec_start), .o_rec_pause(o_rec_pause), .o_rec_stop(o_rec_stop),
    .o_play_start(o_play_start), .o_play_pause(o_play_pause), .o_play_stop(o_play_stop),
    .o_base_addr(o_base_addr), .o_len(o_len)
  );

  int checkCount = 0;
  int passCount  = 0;
  bit checkEn    = 1'b0;

  // Behavioural model: state codes, per-slot lengths, play progress and expected pulses
  int mState, mSlot, mCnt, mIdle;
  int mLen [SLOTS];
  bit mPrevRec, mPrevPlay, mPrevStop;
  bit mInit, mRecStart, mRecPause, mRecStop, mPlayStart, mPlayPause, mPlayStop;

  task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
    checkCount++;
    if (actual === 32'(expected)) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
  endtask

  task automatic modelStep();
    bit recE, playE, stopE, done;
    int spd;
    if (i_rst) begin
      mState = 0; mSlot = 0; mCnt = 0; mIdle = 0;
      for (int i = 0; i < SLOTS; i++) mLen[i] = 0;
      mPrevRec = 1; mPrevPlay = 1; mPrevStop = 1;
      {mInit, mRecStart, mRecPause, mRecStop, mPlayStart, mPlayPause, mPlayStop} = '0;
      return;
    end
    recE  = i_key_rec  && !mPrevRec;
    playE = i_key_play && !mPrevPlay;
    stopE = i_key_stop && !mPrevStop;
    mPrevRec = i_key_rec; mPrevPlay = i_key_play; mPrevStop = i_key_stop;
    {mInit, mRecStart, mRecPause, mRecStop, mPlayStart, mPlayPause, mPlayStop} = '0;
    case (mState)
      0: begin
        if (mIdle == INIT_DLY - 1) begin mIdle = 0; mInit = 1; mState = 1; end
        else mIdle++;
      end
      1: if (i_init_done) mState = 2;
      2: begin
        if (recE) begin
          mSlot = int'(i_slot_sel); mLen[mSlot] = 0; mRecStart = 1; mState = 3;
        end else if (playE) begin
          mSlot = int'(i_slot_sel);
          if (mLen[mSlot] != 0) begin mPlayStart = 1; mCnt = 0; mState = 5; end
        end
      end
      3, 4: begin
        if (mState == 3 && i_sample_tick) mLen[mSlot]++;
        if (stopE || mLen[mSlot] == LMAX) begin mRecStop = 1; mState = 2; end
        else if (recE) begin mRecPause = 1; mState = (mState == 3) ? 4 : 3; end
      end
      5, 6: begin
        if (mState == 5 && i_sample_tick) mCnt++;
        spd  = int'(i_speed[2:0]) + 1;
        done = i_speed[3] ? (mCnt * spd >= mLen[mSlot]) : (mCnt >= mLen[mSlot] * spd);
        if (stopE || done || i_play_finish) begin mPlayStop = 1; mState = 2; end
        else if (playE) begin mPlayPause = 1; mState = (mState == 5) ? 6 : 5; end
      end
      default: mState = 0;
    endcase
  endtask

  always @(posedge i_clk) begin
    #2;
    modelStep();
  end

  // Every output against the model, half a cycle after each edge
  always @(negedge i_clk) begin
    if (checkEn) begin
      checkOutput("state",      o_state,      mState);
      checkOutput("init_start", o_init_start, mInit);
      checkOutput("rec_en",     o_rec_en,     mState == 3);
      checkOutput("play_en",    o_play_en,    mState == 5);
      checkOutput("rec_start",  o_rec_start,  mRecStart);
      checkOutput("rec_pause",  o_rec_pause,  mRecPause);
      checkOutput("rec_stop",   o_rec_stop,   mRecStop);
      checkOutput("play_start", o_play_start, mPlayStart);
      checkOutput("play_pause", o_play_pause, mPlayPause);
      checkOutput("play_stop",  o_play_stop,  mPlayStop);
      checkOutput("base_addr",  o_base_addr,  mSlot << (ADDR_W - SW));
      checkOutput("len",        o_len,        mLen[mSlot]);
    end
  end

  task automatic step();
    @(posedge i_clk);
    #3;
  endtask

  task automatic pressKey(input bit r, input bit p, input bit s);
    i_key_rec = r; i_key_play = p; i_key_stop = s;
    step();
  endtask

  task automatic releaseKeys();
    i_key_rec = 0; i_key_play = 0; i_key_stop = 0;
    step();
  endtask

  task automatic ticks(input int n);
    i_sample_tick = 1;
    repeat (n) step();
    i_sample_tick = 0;
  endtask

  task automatic applyStimulus();
    i_rst         = ($urandom_range(0, 999) == 0);
    i_key_rec     = ($urandom_range(0, 9) == 0);
    i_key_play    = ($urandom_range(0, 7) == 0);
    i_key_stop    = ($urandom_range(0, 29) == 0);
    i_slot_sel    = SW'($urandom_range(0, SLOTS - 1));
    i_init_done   = ($urandom_range(0, 5) == 0);
    i_sample_tick = ($urandom_range(0, 1) == 0);
    i_play_finish = ($urandom_range(0, 199) == 0);
    if (mState == 2 && $urandom_range(0, 9) == 0) i_speed = 5'($urandom_range(0, 31));
    step();
  endtask

  initial begin
    step();
    checkEn = 1'b1;
    step();
    checkOutput("reset_state", o_state, 0);
    checkOutput("reset_len", o_len, 0);

    // Init handshake: pulse at cycle 3, AWAIT at cycle 11
    i_rst = 0;
    for (int c = 1; c <= 11; c++) begin
      if (c == 11) i_init_done = 1;
      step();
      if (c == 2)  checkOutput("init_c2", o_init_start, 0);
      if (c == 3)  begin checkOutput("init_c3", o_init_start, 1); checkOutput("state_c3", o_state, 1); end
      if (c == 4)  checkOutput("init_c4", o_init_start, 0);
      if (c == 10) checkOutput("state_c10", o_state, 1);
      if (c == 11) checkOutput("state_c11", o_state, 2);
    end
    i_init_done = 0;

    // Record slot 2: 5 ticks, pause, 3 ignored ticks, resume, 2 ticks, stop
    i_slot_sel = 2;
    pressKey(1, 0, 0);
    checkOutput("rec_start_lit", o_rec_start, 1);
    checkOutput("rec_state_lit", o_state, 3);
    releaseKeys();
    ticks(5);
    pressKey(1, 0, 0);
    checkOutput("rec_pause_lit", o_state, 4);
    releaseKeys();
    ticks(3);
    pressKey(1, 0, 0);
    releaseKeys();
    ticks(2);
    pressKey(0, 0, 1);
    checkOutput("rec_stop_lit", o_rec_stop, 1);
    checkOutput("rec_base_lit", o_base_addr, 8'h80);
    checkOutput("rec_len_lit", o_len, 7);
    releaseKeys();
    checkOutput("rec_stop_once", o_rec_stop, 0);

    // Saturation on slot 1
    i_slot_sel = 1;
    pressKey(1, 0, 0);
    releaseKeys();
    i_sample_tick = 1;
    for (int k = 1; k <= 70; k++) begin
      step();
      if (k == 63) checkOutput("sat_k63_state", o_state, 3);
      if (k == 64) begin
        checkOutput("sat_stop", o_rec_stop, 1);
        checkOutput("sat_state", o_state, 2);
      end
    end
    i_sample_tick = 0;
    checkOutput("sat_len", o_len, 64);

    // Slow x2 playback of slot 2 (length 7): stop after tick 14
    i_slot_sel = 2;
    i_speed = 5'b00001;
    pressKey(0, 1, 0);
    checkOutput("play_start_lit", o_play_start, 1);
    releaseKeys();
    i_sample_tick = 1;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 13) checkOutput("slow_k13", o_play_stop, 0);
      if (k == 14) begin
        checkOutput("slow_k14", o_play_stop, 1);
        checkOutput("slow_state", o_state, 2);
      end
    end
    i_sample_tick = 0;

    // Fast x4 playback: stop after tick 2
    i_speed = 5'b01011;
    pressKey(0, 1, 0);
    releaseKeys();
    i_sample_tick = 1;
    step();
    checkOutput("fast_k1", o_play_stop, 0);
    step();
    checkOutput("fast_k2", o_play_stop, 1);
    i_sample_tick = 0;

    // Empty slot 3 cannot be played
    i_slot_sel = 3;
    pressKey(0, 1, 0);
    checkOutput("empty_start", o_play_start, 0);
    checkOutput("empty_state", o_state, 2);
    releaseKeys();

    // Simultaneous rec and play edges: rec wins; record 3 frames into slot 0
    i_slot_sel = 0;
    pressKey(1, 1, 0);
    checkOutput("both_state", o_state, 3);
    checkOutput("both_pstart", o_play_start, 0);
    releaseKeys();
    ticks(3);
    pressKey(0, 0, 1);
    releaseKeys();

    // Stop and play edges together while playing: one stop, no pause
    i_speed = 5'b00000;
    pressKey(0, 1, 0);
    releaseKeys();
    pressKey(0, 1, 1);
    checkOutput("sp_stop", o_play_stop, 1);
    checkOutput("sp_pause", o_play_pause, 0);
    checkOutput("sp_state", o_state, 2);
    releaseKeys();
    checkOutput("sp_once", o_play_stop, 0);

    // Reset from PLAY_PAUSE clears everything
    pressKey(0, 1, 0);
    releaseKeys();
    pressKey(0, 1, 0);
    checkOutput("pp_state", o_state, 6);
    releaseKeys();
    i_rst = 1;
    step();
    checkOutput("rst_state", o_state, 0);
    checkOutput("rst_len", o_len, 0);
    checkOutput("rst_play_en", o_play_en, 0);
    i_rst = 0;
    repeat (3) step();
    i_init_done = 1;
    step();
    i_init_done = 0;
    checkOutput("reinit_state", o_state, 2);
    i_slot_sel = 2;
    pressKey(0, 1, 0);
    checkOutput("cleared_slot2", o_state, 2);
    checkOutput("cleared_len2", o_len, 0);
    releaseKeys();

    repeat (6000) applyStimulus();

    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
